i2c_reg_ctrl: RTL and testbench
===============================

Name: i2c_reg_ctrl

Overview:
Register-access sequencer that sits directly upstream of the I2C byte shift engine. It converts one register read or write request into the engine's byte-level command sequence:
- write: START+device address, register address, data byte, STOP;
- read: START+device address (write), register address, repeated START+device address (read), one read byte with NACK, STOP.

Each byte is driven over the engine's cmd/go/data_tx interface, and the block consumes trans_done/ack_o/data_rx. Host-side results are returned as a done pulse with error flag and read data.

Parameters:
CMD_WR_STA, 6'd0, engine command code: generate START, then shift out data_tx, then check ACK
CMD_WR, 6'd2, engine command code: shift out data_tx, then check ACK (no START)
CMD_RD_NACK, 6'd6, engine command code: shift in one byte, then master drives NACK
CMD_STO, 6'd3, engine command code: generate STOP
TIMEOUT_CYCLES, 65535, clk cycles allowed per engine transfer (used only with I2C_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
req  input  1  start request, sampled in IDLE only
rw  input  1  0=register write, 1=register read; captured with req
dev_addr  input  7  7-bit slave address; captured with req
reg_addr  input  8  register address; captured with req
wdata  input  8  write data; captured with req
busy  output  1  high from the cycle after req is accepted until done
done  output  1  one-cycle pulse at end of every accepted request
err  output  1  valid with done; 1 = NACK received or timeout
rdata  output  8  read result; updated only on a successful read
sh_go  output  1  one-cycle start strobe to the shift engine
sh_cmd  output  6  command to the engine; held stable from sh_go until sh_trans_done
sh_data_tx  output  8  byte to the engine; held stable with sh_cmd
sh_trans_done  input  1  engine one-cycle completion pulse
sh_ack  input  1  engine ACK bit sampled from SDA (0=ACK, 1=NACK)
sh_data_rx  input  8  engine received byte, valid at sh_trans_done

Behaviour:
- Reset (async, rst_n low): all outputs 0; state IDLE; captured request registers 0; timeout counter 0.
- Request capture: in IDLE, when req=1, capture rw/dev_addr/reg_addr/wdata and set busy next cycle. req while busy is ignored; no queuing.
- Byte step: every byte step has two phases.
  - ISSUE (1 cycle): sh_go=1 with sh_cmd/sh_data_tx valid.
  - WAIT: sh_go=0; hold until sh_trans_done=1.
  - sh_cmd/sh_data_tx change only in ISSUE.
- States and command/data per step:
  - IDLE
  - DEV_W: CMD_WR_STA, data {dev_addr,1'b0}
  - REG: CMD_WR, data reg_addr
  - WDATA: CMD_WR, data wdata
  - DEV_R: CMD_WR_STA, data {dev_addr,1'b1}
  - RDATA: CMD_RD_NACK, data 8'hFF
  - STOP: CMD_STO, data 8'h00
  - FIN
- Transitions (evaluated at sh_trans_done):
  - DEV_W→REG.
  - REG→WDATA if rw=0; REG→DEV_R if rw=1.
  - WDATA→STOP.
  - DEV_R→RDATA.
  - RDATA→STOP; rdata<=sh_data_rx in the same cycle.
  - STOP→FIN.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- NACK abort: in DEV_W/REG/WDATA/DEV_R, sh_ack=1 at sh_trans_done sets the sticky err_r flag and goes directly to STOP. STOP is always issued, so the bus is never left held. rdata keeps its old value.
- sh_ack is ignored in RDATA and STOP.
- err output: equals err_r during the done pulse, holds until the next accepted req, and is cleared on acceptance.
- Latency: req→first sh_go = 2 cycles. Last sh_trans_done (STOP)→done = 1 cycle.
- Simultaneous events: sh_trans_done arriving in the ISSUE cycle is treated as belonging to that step.
- Spurious sh_trans_done in IDLE/FIN is ignored.

Optional Feature:
I2C_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on every sh_go and increments in WAIT.
  - When it reaches TIMEOUT_CYCLES before sh_trans_done: set err_r, go to FIN (no STOP, since the engine is unresponsive), pulse done with err=1.
  - A timeout while in STOP also goes to FIN with err=1.
- Undefined: no counter logic is present, and WAIT waits indefinitely.

Test Plan:
- Write: req rw=0 dev=7'h50 reg=8'h10 wdata=8'hA5; engine model always ACKs → sh_cmd/data sequence (0,8'hA0),(2,8'h10),(2,8'hA5),(3,8'h00); done=1, err=0; busy high throughout.
- Read: req rw=1 dev=7'h50 reg=8'h22; model returns 8'h3C on RDATA → sequence (0,A0),(2,22),(0,A1),(6,FF),(3,00); rdata=8'h3C, err=0.
- NACK on device address: model returns sh_ack=1 on the first byte → next command is CMD_STO; done with err=1; rdata unchanged; no REG step.
- Busy/req interplay: pulse req during WAIT of REG → ignored, sequence unchanged; after done, new req accepted and err cleared.
- Reset mid-operation: assert rst_n=0 during RDATA WAIT → busy/done/err/sh_go=0 immediately; after release, a new write completes normally.
- With I2C_TIMEOUT_EN and TIMEOUT_CYCLES=100: model never returns trans_done on REG → done+err=1 exactly 100 cycles after the REG sh_go; no STOP command issued.

Source files
------------

// File: rtl/i2c_reg_ctrl.sv
// rtl/i2c_reg_ctrl.sv - register read/write sequencer driving an I2C byte shift engine
// Optional build macro: I2C_TIMEOUT_EN (per-transfer watchdog, adds TIMEOUT_CYCLES parameter)
module i2c_reg_ctrl #(
  parameter logic [5:0] CMD_WR_STA  = 6'd0,
  parameter logic [5:0] CMD_WR      = 6'd2,
  parameter logic [5:0] CMD_RD_NACK = 6'd6,
  parameter logic [5:0] CMD_STO     = 6'd3
`ifdef I2C_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rdata,
  output logic       sh_go,
  output logic [5:0] sh_cmd,
  output logic [7:0] sh_data_tx,
  input  logic       sh_trans_done,
  input  logic       sh_ack,
  input  logic [7:0] sh_data_rx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEV_W,
    S_REG,
    S_WDATA,
    S_DEV_R,
    S_RDATA,
    S_STOP,
    S_FIN
  } state_t;

  state_t     state;
  state_t     ok_next;
  logic       issued;     // 0: step not yet sent to engine, 1: ISSUE/WAIT phase
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;
  logic       err_r;      // sticky NACK/timeout flag for the current request
  logic [5:0] step_cmd;
  logic [7:0] step_data;

`ifdef I2C_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt;
`endif

  // Engine command and byte belonging to the current step
  always_comb begin
    step_cmd  = CMD_STO;
    step_data = 8'h00;
    case (state)
      S_DEV_W: begin
        step_cmd  = CMD_WR_STA;
        step_data = {dev_q, 1'b0};
      end
      S_REG: begin
        step_cmd  = CMD_WR;
        step_data = reg_q;
      end
      S_WDATA: begin
        step_cmd  = CMD_WR;
        step_data = wdata_q;
      end
      S_DEV_R: begin
        step_cmd  = CMD_WR_STA;
        step_data = {dev_q, 1'b1};
      end
      S_RDATA: begin
        step_cmd  = CMD_RD_NACK;
        step_data = 8'hFF;
      end
      default: begin
        step_cmd  = CMD_STO;
        step_data = 8'h00;
      end
    endcase
  end

  // Successor step when the current byte completed with ACK
  always_comb begin
    ok_next = S_STOP;
    case (state)
      S_DEV_W: ok_next = S_REG;
      S_REG:   ok_next = rw_q ? S_DEV_R : S_WDATA;
      S_WDATA: ok_next = S_STOP;
      S_DEV_R: ok_next = S_RDATA;
      S_RDATA: ok_next = S_STOP;
      S_STOP:  ok_next = S_FIN;
      default: ok_next = S_STOP;
    endcase
  end

  // Sequencer FSM with registered host and engine outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      issued     <= 1'b0;
      rw_q       <= 1'b0;
      dev_q      <= 7'd0;
      reg_q      <= 8'd0;
      wdata_q    <= 8'd0;
      err_r      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= 8'd0;
      sh_go      <= 1'b0;
      sh_cmd     <= 6'd0;
      sh_data_tx <= 8'd0;
`ifdef I2C_TIMEOUT_EN
      to_cnt     <= 16'd0;
`endif
    end else begin
      sh_go <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            rw_q    <= rw;
            dev_q   <= dev_addr;
            reg_q   <= reg_addr;
            wdata_q <= wdata;
            err_r   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            issued  <= 1'b0;
            state   <= S_DEV_W;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          if (!issued) begin
            // Present the step to the engine; cmd/data stay put until the next step
            sh_go      <= 1'b1;
            sh_cmd     <= step_cmd;
            sh_data_tx <= step_data;
            issued     <= 1'b1;
`ifdef I2C_TIMEOUT_EN
            to_cnt     <= 16'd0;
`endif
          end else if (sh_trans_done) begin
            issued <= 1'b0;
            if (state == S_STOP) begin
              state <= S_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= err_r;
            end else if (state == S_RDATA) begin
              // Read byte is taken regardless of the ack bit, which we drove as NACK
              rdata <= sh_data_rx;
              state <= S_STOP;
            end else if (sh_ack) begin
              // Slave refused: still release the bus with a STOP
              err_r <= 1'b1;
              state <= S_STOP;
            end else begin
              state <= ok_next;
            end
          end
`ifdef I2C_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            // Engine is unresponsive; a STOP would hang the same way, so finish now
            issued <= 1'b0;
            err_r  <= 1'b1;
            err    <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_FIN;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb/tb_i2c_reg_ctrl.sv - self-checking bench for i2c_reg_ctrl with a behavioural engine model
module tb_i2c_reg_ctrl;

  localparam logic [5:0] C_STA = 6'd0;
  localparam logic [5:0] C_WR  = 6'd2;
  localparam logic [5:0] C_RDN = 6'd6;
  localparam logic [5:0] C_STO = 6'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic       rw;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] rdata;
  logic       sh_go;
  logic [5:0] sh_cmd;
  logic [7:0] sh_data_tx;
  logic       sh_trans_done;
  logic       sh_ack;
  logic [7:0] sh_data_rx;

`ifdef I2C_TIMEOUT_EN
  i2c_reg_ctrl #(.TIMEOUT_CYCLES(100)) dut (
`else
  i2c_reg_ctrl dut (
`endif
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .sh_go(sh_go), .sh_cmd(sh_cmd), .sh_data_tx(sh_data_tx),
    .sh_trans_done(sh_trans_done), .sh_ack(sh_ack), .sh_data_rx(sh_data_rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rw;
    bit [6:0] dev;
    bit [7:0] rg;
    bit [7:0] wd;
    bit [7:0] rx;
    int       nack;   // byte index the slave NACKs, -1 for none
    int       lat;    // engine wait cycles after sh_go
    bit       poke;   // pulse req while REG is waiting
    bit       exp_err;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [13:0] log_q[$];
  logic [13:0] exp_q[$];
  int          go_c[$];
  int          stop_td_c;
  int          stab_err = 0;
  int          cur_nack = -1;
  int          cur_hang = -1;
  int          cur_lat = 0;
  logic [7:0]  cur_rx = 8'h00;
  logic [7:0]  mdl_rdata = 8'h00;
  bit          eng_pending;
  int          eng_cnt;
  logic [5:0]  eng_cmd;
  logic [7:0]  eng_data;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Engine model: logs each issued byte, answers after cur_lat cycles
  initial begin
    int idx;
    sh_trans_done = 1'b0;
    sh_ack = 1'b0;
    sh_data_rx = 8'h00;
    eng_pending = 1'b0;
    forever begin
      @(negedge clk);
      sh_trans_done = 1'b0;
      if (!rst_n || done) eng_pending = 1'b0;
      if (rst_n && sh_go) begin
        log_q.push_back({sh_cmd, sh_data_tx});
        go_c.push_back(cyc);
        eng_pending = 1'b1;
        eng_cnt = cur_lat;
        eng_cmd = sh_cmd;
        eng_data = sh_data_tx;
      end else if (eng_pending && (sh_cmd !== eng_cmd || sh_data_tx !== eng_data)) begin
        stab_err++;
      end
      idx = log_q.size() - 1;
      if (eng_pending && idx != cur_hang) begin
        if (eng_cnt == 0) begin
          sh_trans_done = 1'b1;
          sh_data_rx = cur_rx;
          if (eng_cmd == C_RDN) sh_ack = 1'b1;
          else if (eng_cmd == C_STO) sh_ack = 1'($urandom_range(0, 1));
          else sh_ack = (idx == cur_nack);
          if (eng_cmd == C_STO) stop_td_c = cyc;
          eng_pending = 1'b0;
        end else begin
          eng_cnt--;
        end
      end
    end
  end

  // Reference: byte sequence a request should produce on the engine interface
  task automatic build_exp(input vec_t v);
    exp_q.delete();
    exp_q.push_back({C_STA, v.dev, 1'b0});
    exp_q.push_back({C_WR, v.rg});
    if (v.rw) begin
      exp_q.push_back({C_STA, v.dev, 1'b1});
      exp_q.push_back({C_RDN, 8'hFF});
    end else begin
      exp_q.push_back({C_WR, v.wd});
    end
    if (v.nack >= 0)
      while (exp_q.size() > v.nack + 1) void'(exp_q.pop_back());
    exp_q.push_back({C_STO, 8'h00});
  endtask

  task automatic start_req(input vec_t v, output int req_c);
    log_q.delete();
    go_c.delete();
    stop_td_c = -1;
    cur_nack = v.nack;
    cur_rx = v.rx;
    cur_lat = v.lat;
    @(negedge clk);
    rw = v.rw; dev_addr = v.dev; reg_addr = v.rg; wdata = v.wd;
    req = 1'b1;
    req_c = cyc;
    @(negedge clk);
    req = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_err_clr", 32'(err), 32'd0);
  endtask

  task automatic run(input vec_t v, input string tag);
    int req_c;
    int done_c;
    int st0;
    bit busy_bad;
    bit poked;
    logic [7:0] exp_rd;
    build_exp(v);
    exp_rd = (v.rw && v.nack < 0) ? v.rx : mdl_rdata;
    st0 = stab_err;
    start_req(v, req_c);
    busy_bad = 1'b0;
    poked = 1'b0;
    done_c = -1;
    for (int t = 0; t < 2000; t++) begin
      if (done) begin
        done_c = cyc;
        break;
      end
      if (!busy) busy_bad = 1'b1;
      if (v.poke && !poked && log_q.size() == 2 && eng_pending) begin
        req = 1'b1; rw = ~v.rw; dev_addr = ~v.dev; reg_addr = 8'hEE; wdata = 8'h11;
        poked = 1'b1;
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
    end
    req = 1'b0;
    if (done_c < 0) begin
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
      return;
    end
    mdl_rdata = exp_rd;
    chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
    chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
    chk({tag, "_busy_held"}, 32'(busy_bad), 32'd0);
    chk({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_stable"}, 32'(stab_err - st0), 32'd0);
    chk({tag, "_req_to_go"}, 32'(go_c[0] - req_c), 32'd2);
    chk({tag, "_stop_to_done"}, 32'(done_c - stop_td_c), 32'd1);
    chk({tag, "_nbytes"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk({tag, "_byte"}, 32'(log_q[i]), 32'(exp_q[i]));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [13:0] plan_w[4];
    logic [13:0] plan_r[5];
    vec_t v;
    int req_c;
    bit hit;

    plan_w = '{14'h00A0, 14'h0210, 14'h02A5, 14'h0300};
    plan_r = '{14'h00A0, 14'h0222, 14'h00A1, 14'h06FF, 14'h0300};

    rst_n = 1'b0; req = 1'b0; rw = 1'b0;
    dev_addr = 7'h00; reg_addr = 8'h00; wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_go", 32'(sh_go), 32'd0);
    chk("rst_cmd", 32'({sh_cmd, sh_data_tx}), 32'd0);
    rst_n = 1'b1;

    vecs[0] = '{rw:0, dev:7'h50, rg:8'h10, wd:8'hA5, rx:8'h00, nack:-1, lat:2, poke:0, exp_err:0};
    vecs[1] = '{rw:1, dev:7'h50, rg:8'h22, wd:8'h00, rx:8'h3C, nack:-1, lat:1, poke:0, exp_err:0};
    vecs[2] = '{rw:1, dev:7'h50, rg:8'h22, wd:8'h00, rx:8'h77, nack:0, lat:0, poke:0, exp_err:1};
    vecs[3] = '{rw:0, dev:7'h2B, rg:8'h05, wd:8'h5A, rx:8'h00, nack:-1, lat:4, poke:1, exp_err:0};
    for (int i = 4; i < 24; i++) begin
      vecs[i].rw = 1'($urandom_range(0, 1));
      vecs[i].dev = 7'($urandom);
      vecs[i].rg = 8'($urandom);
      vecs[i].wd = 8'($urandom);
      vecs[i].rx = 8'($urandom);
      vecs[i].nack = $urandom_range(0, 5);
      if (vecs[i].nack > 2) vecs[i].nack = -1;
      vecs[i].lat = $urandom_range(0, 4);
      vecs[i].poke = 1'($urandom_range(0, 1));
      if (vecs[i].lat < 2) vecs[i].poke = 1'b0;
      vecs[i].exp_err = (vecs[i].nack >= 0);
    end

    for (int i = 0; i < 24; i++) begin
      run(vecs[i], $sformatf("v%0d", i));
      if (i == 0)
        for (int k = 0; k < 4; k++) chk("plan_write_seq", 32'(log_q[k]), 32'(plan_w[k]));
      if (i == 1)
        for (int k = 0; k < 5; k++) chk("plan_read_seq", 32'(log_q[k]), 32'(plan_r[k]));
    end

    // Reset while the read byte is outstanding
    v = '{rw:1, dev:7'h31, rg:8'h40, wd:8'h00, rx:8'h99, nack:-1, lat:8, poke:0, exp_err:0};
    start_req(v, req_c);
    hit = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (log_q.size() == 4 && eng_pending) begin
        hit = 1'b1;
        break;
      end
    end
    chk("rst_mid_reached_rdata", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    chk("rst_mid_go", 32'(sh_go), 32'd0);
    mdl_rdata = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(vecs[0], "after_rst");

`ifdef I2C_TIMEOUT_EN
    // Engine never answers the register-address byte
    cur_hang = 1;
    v = '{rw:0, dev:7'h12, rg:8'h34, wd:8'h56, rx:8'h00, nack:-1, lat:1, poke:0, exp_err:1};
    start_req(v, req_c);
    hit = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      if (done) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("to_done_seen", 32'(hit), 32'd1);
    if (hit && go_c.size() >= 2) chk("to_latency", 32'(cyc - go_c[1]), 32'd100);
    chk("to_err", 32'(err), 32'd1);
    chk("to_no_stop", 32'(log_q.size()), 32'd2);
    chk("to_rdata_kept", 32'(rdata), 32'(mdl_rdata));
    cur_hang = -1;
    @(negedge clk);
    run(vecs[1], "after_to");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
